// File: rtl/player_input_controller_pkg.sv
// Shared game definitions: attack phase encodings and the game-tick rate.
package player_input_controller_pkg;

    typedef enum logic [1:0] {
        ATK_IDLE     = 2'd0,
        ATK_STARTUP  = 2'd1,
        ATK_ACTIVE   = 2'd2,
        ATK_RECOVERY = 2'd3
    } atk_phase_e;

    localparam int GAME_TICK_HZ = 20;

endpackage

// File: rtl/player_input_controller_button_debouncer.sv
// Two-flop synchroniser, counter-based debouncer and rising-edge pulse for one raw button.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // The accepted level flips only after the synchronised input has disagreed with it
    // for DEBOUNCE_CYCLES consecutive clocks; rise fires in the cycle stable goes high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync   <= '0;
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            rise <= 1'b0;
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync[1];
                rise   <= sync[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/player_input_controller.sv
// Turns debounced buttons into tick-aligned movement, jump and attack-phase outputs for the physics engine.
module player_input_controller
    import player_input_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STARTUP_TICKS   = 2,
    parameter int ACTIVE_TICKS    = 3,
    parameter int RECOVERY_TICKS  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       game_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic       btn_attack,
    output logic       movingLeft,
    output logic       movingRight,
    output logic       isJumping,
    output logic [1:0] attack_phase,
    output logic       attack_hit
);

    localparam logic [3:0] STARTUP_LOAD  = 4'(STARTUP_TICKS - 1);
    localparam logic [3:0] ACTIVE_LOAD   = 4'(ACTIVE_TICKS - 1);
    localparam logic [3:0] RECOVERY_LOAD = 4'(RECOVERY_TICKS - 1);

    logic [3:0] raw_bus;
    logic [3:0] st;
    logic [3:0] rise;
    logic       unused_bits;

    atk_phase_e phase, phase_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       jump_pend, atk_pend;
    logic       idle_nxt;

    // Button order: 0 left, 1 right, 2 jump, 3 attack.
    assign raw_bus = {btn_attack, btn_jump, btn_right, btn_left};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk    (clk),
            .reset  (reset),
            .raw    (raw_bus[i]),
            .stable (st[i]),
            .rise   (rise[i])
        );
    end

    assign unused_bits = ^{st[3:2], rise[1:0]};

    always_comb begin
        phase_nxt = phase;
        cnt_nxt   = cnt;
        if (game_tick) begin
            unique case (phase)
                ATK_IDLE: begin
                    if (atk_pend) begin
                        phase_nxt = ATK_STARTUP;
                        cnt_nxt   = STARTUP_LOAD;
                    end
                end
                ATK_STARTUP: begin
                    if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
                    else begin
                        phase_nxt = ATK_ACTIVE;
                        cnt_nxt   = ACTIVE_LOAD;
                    end
                end
                ATK_ACTIVE: begin
                    if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
                    else begin
                        phase_nxt = ATK_RECOVERY;
                        cnt_nxt   = RECOVERY_LOAD;
                    end
                end
                ATK_RECOVERY: begin
                    if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
                    else begin
                        phase_nxt = ATK_IDLE;
                        cnt_nxt   = 4'd0;
                    end
                end
            endcase
        end
    end

    assign idle_nxt = (phase_nxt == ATK_IDLE);

    // A new edge wins over the tick that clears its pending flag, so it survives to the next tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase       <= ATK_IDLE;
            cnt         <= 4'd0;
            jump_pend   <= 1'b0;
            atk_pend    <= 1'b0;
            movingLeft  <= 1'b0;
            movingRight <= 1'b0;
            isJumping   <= 1'b0;
            attack_hit  <= 1'b0;
        end else begin
            phase     <= phase_nxt;
            cnt       <= cnt_nxt;
            jump_pend <= rise[2] | (jump_pend & ~game_tick);
            atk_pend  <= rise[3] | (atk_pend & ~game_tick);
            if (game_tick) begin
                movingLeft  <= st[0] & ~st[1] & idle_nxt;
                movingRight <= st[1] & ~st[0] & idle_nxt;
                isJumping   <= jump_pend & idle_nxt;
                attack_hit  <= (phase_nxt == ATK_ACTIVE);
            end
        end
    end

    assign attack_phase = phase;

endmodule
